async_fifo_gray: RTL and testbench

Parametrised dual-clock FIFO with Gray-coded pointers crossed through multi-stage synchronizers, fill-level counts in both domains, programmable almost-full/almost-empty thresholds and single-cycle overflow/underflow pulses. Successor to the team's basic asynchronous FIFO; sits between any two unrelated clock domains in the datapath (producer on wr_clk, consumer on rd_clk).

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/sync_bus.sv | 39 +++
 rtl/async_fifo_gray.sv | 156 +++++++++++++++
 tb/tb_async_fifo_gray.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the Gray-pointer asynchronous FIFO: width-generic Gray
// conversion and the default synchronizer depth.
package fifo_pkg;

    localparam int DEFAULT_SYNC_STAGES = 2;

    // Conversions work on a wide word; callers zero-extend in and truncate out.
    localparam int GRAY_W = 32;
    typedef logic [GRAY_W-1:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic gray_word_t gray2bin(input gray_word_t gray);
        gray_word_t bin;
        bin[GRAY_W-1] = gray[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/sync_bus.sv
// Multi-flop synchronizer chain with synchronous clear. Only Gray-coded buses
// or single bits may be passed through it.
module sync_bus
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    // NOTE: combinational blocks use blocking '=' so later lines see earlier
    // results; clocked blocks use '<=' so every flop samples pre-edge values.
    always_comb begin
        stage_d[0] = d_i;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (clr_i) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO: binary pointers with registered Gray copies, Gray pointers
// crossed through sync_bus chains, per-domain fill counts and threshold flags.
module async_fifo_gray
    import fifo_pkg::*;
#(
    parameter  int DEPTH       = 16,
    parameter  int DATA_WIDTH  = 8,
    parameter  int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter  int AF_LEVEL    = DEPTH - 2,
    parameter  int AE_LEVEL    = 2,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                  wr_clk,
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic [ADDR_W:0]       wr_count_o,
    output logic                  overflow_o,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  empty_o,
    output logic                  almost_empty_o,
    output logic [ADDR_W:0]       rd_count_o,
    output logic                  underflow_o
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] AF_THR = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] AE_THR = PTR_W'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // ---------------- write domain ----------------
    logic [PTR_W-1:0] wr_bin_q, wr_bin_d;
    logic [PTR_W-1:0] wr_gray_q, wr_gray_d;
    logic [PTR_W-1:0] rd_gray_sync;
    logic [PTR_W-1:0] wr_count;
    logic             overflow_q, overflow_d;
    logic             wr_full;
    logic             wr_accept;

    // ---------------- read domain -----------------
    logic [PTR_W-1:0]      rd_bin_q, rd_bin_d;
    logic [PTR_W-1:0]      rd_gray_q, rd_gray_d;
    logic [PTR_W-1:0]      wr_gray_sync;
    logic [PTR_W-1:0]      rd_count;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_empty;
    logic                  rd_accept;
    logic                  rd_rst;

    sync_bus #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_rd_gray_sync (
        .clk   (wr_clk),
        .clr_i (rst),
        .d_i   (rd_gray_q),
        .q_o   (rd_gray_sync)
    );

    sync_bus #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_wr_gray_sync (
        .clk   (rd_clk),
        .clr_i (rd_rst),
        .d_i   (wr_gray_q),
        .q_o   (wr_gray_sync)
    );

    // Reset reaches the read side only through its own synchronizer.
    sync_bus #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_rst_sync (
        .clk   (rd_clk),
        .clr_i (1'b0),
        .d_i   (rst),
        .q_o   (rd_rst)
    );

    // Full when the writer is exactly one lap ahead: top two Gray bits inverted.
    assign wr_full  = (wr_gray_q == {~rd_gray_sync[ADDR_W -: 2], rd_gray_sync[ADDR_W-2:0]});
    assign wr_count = wr_bin_q - PTR_W'(gray2bin(GRAY_W'(rd_gray_sync)));

    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wr_bin_d   = wr_bin_q;
        wr_gray_d  = wr_gray_q;
        wr_accept  = wr_en_i && !wr_full && !rst;
        overflow_d = wr_en_i && wr_full && !rst;
        if (wr_accept) begin
            wr_bin_d  = wr_bin_q + PTR_W'(1);
            wr_gray_d = PTR_W'(bin2gray(GRAY_W'(wr_bin_d)));
        end
    end

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            wr_bin_q   <= '0;
            wr_gray_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_bin_q   <= wr_bin_d;
            wr_gray_q  <= wr_gray_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array has no reset; pointers alone define validity,
    // and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge wr_clk) begin
        if (wr_accept) begin
            mem_q[wr_bin_q[ADDR_W-1:0]] <= wdata_i;
        end
    end

    assign rd_empty = (rd_gray_q == wr_gray_sync);
    assign rd_count = PTR_W'(gray2bin(GRAY_W'(wr_gray_sync))) - rd_bin_q;

    always_comb begin
        rd_bin_d    = rd_bin_q;
        rd_gray_d   = rd_gray_q;
        rdata_d     = rdata_q;
        rd_accept   = rd_en_i && !rd_empty && !rd_rst;
        underflow_d = rd_en_i && rd_empty && !rd_rst;
        if (rd_accept) begin
            rdata_d   = mem_q[rd_bin_q[ADDR_W-1:0]];
            rd_bin_d  = rd_bin_q + PTR_W'(1);
            rd_gray_d = PTR_W'(bin2gray(GRAY_W'(rd_bin_d)));
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_bin_q    <= '0;
            rd_gray_q   <= '0;
            rdata_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            rd_bin_q    <= rd_bin_d;
            rd_gray_q   <= rd_gray_d;
            rdata_q     <= rdata_d;
            underflow_q <= underflow_d;
        end
    end

    assign full_o         = wr_full;
    assign almost_full_o  = (wr_count >= AF_THR);
    assign wr_count_o     = wr_count;
    assign overflow_o     = overflow_q;

    assign rdata_o        = rdata_q;
    assign empty_o        = rd_empty;
    assign almost_empty_o = (rd_count <= AE_THR);
    assign rd_count_o     = rd_count;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_async_fifo_gray.sv
// Bench for async_fifo_gray: directed fill/drain/latency/reset steps on a
// default and a small instance, plus a randomized run against a queue model.
`timescale 1ns/100ps
module tb_async_fifo_gray;

    logic    wr_clk = 1'b0;
    logic    rd_clk = 1'b0;
    realtime rd_half = 8.5;

    always #5 wr_clk = ~wr_clk;
    always #(rd_half) rd_clk = ~rd_clk;

    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       sel = 1'b0;   // 0: default instance, 1: small instance

    // default instance (DEPTH 16, SYNC 2, AF 14, AE 2)
    logic       d_full, d_af, d_ovf, d_empty, d_ae, d_unf;
    logic [4:0] d_wr_count, d_rd_count;
    logic [7:0] d_rdata;
    // small instance (DEPTH 4, SYNC 3, AF 3, AE 1)
    logic       s_full, s_af, s_ovf, s_empty, s_ae, s_unf;
    logic [2:0] s_wr_count, s_rd_count;
    logic [7:0] s_rdata;

    async_fifo_gray dut (
        .wr_clk(wr_clk), .rd_clk(rd_clk), .rst(rst),
        .wr_en_i(wr_en && !sel), .wdata_i(wdata),
        .full_o(d_full), .almost_full_o(d_af), .wr_count_o(d_wr_count), .overflow_o(d_ovf),
        .rd_en_i(rd_en && !sel), .rdata_o(d_rdata),
        .empty_o(d_empty), .almost_empty_o(d_ae), .rd_count_o(d_rd_count), .underflow_o(d_unf)
    );

    async_fifo_gray #(.DEPTH(4), .SYNC_STAGES(3), .AF_LEVEL(3), .AE_LEVEL(1)) dut_s (
        .wr_clk(wr_clk), .rd_clk(rd_clk), .rst(rst),
        .wr_en_i(wr_en && sel), .wdata_i(wdata),
        .full_o(s_full), .almost_full_o(s_af), .wr_count_o(s_wr_count), .overflow_o(s_ovf),
        .rd_en_i(rd_en && sel), .rdata_o(s_rdata),
        .empty_o(s_empty), .almost_empty_o(s_ae), .rd_count_o(s_rd_count), .underflow_o(s_unf)
    );

    logic       o_full, o_af, o_ovf, o_empty, o_ae, o_unf;
    logic [4:0] o_wr_count, o_rd_count;
    logic [7:0] o_rdata;

    assign o_full     = sel ? s_full  : d_full;
    assign o_af       = sel ? s_af    : d_af;
    assign o_ovf      = sel ? s_ovf   : d_ovf;
    assign o_empty    = sel ? s_empty : d_empty;
    assign o_ae       = sel ? s_ae    : d_ae;
    assign o_unf      = sel ? s_unf   : d_unf;
    assign o_rdata    = sel ? s_rdata : d_rdata;
    assign o_wr_count = sel ? {2'b00, s_wr_count} : d_wr_count;
    assign o_rd_count = sel ? {2'b00, s_rd_count} : d_rd_count;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Both cycle tasks start and end 1 ns after the active edge of their clock.
    task automatic wr_cycle(input logic en, input logic [7:0] d);
        wr_en = en;
        wdata = d;
        @(posedge wr_clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic rd_cycle(input logic en);
        rd_en = en;
        @(posedge rd_clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_full",         o_full,     0);
        check("rst_almost_full",  o_af,       0);
        check("rst_wr_count",     o_wr_count, 0);
        check("rst_overflow",     o_ovf,      0);
        check("rst_empty",        o_empty,    1);
        check("rst_almost_empty", o_ae,       1);
        check("rst_rd_count",     o_rd_count, 0);
        check("rst_underflow",    o_unf,      0);
        check("rst_rdata",        o_rdata,    0);
    endtask

    task automatic fill_and_overflow(input int depth, input int af, input int sync);
        for (int i = 0; i < depth; i++) begin
            wr_cycle(1'b1, 8'(i));
            model.push_back(8'(i));
            check("fill_wr_count",    o_wr_count, i + 1);
            check("fill_almost_full", o_af,       (i + 1) >= af);
            check("fill_full",        o_full,     (i + 1) == depth);
            check("fill_overflow",    o_ovf,      0);
        end
        wr_cycle(1'b1, 8'hEE);
        check("ovf_pulse",    o_ovf,      1);
        check("ovf_full",     o_full,     1);
        check("ovf_wr_count", o_wr_count, depth);
        wr_cycle(1'b0, 8'h00);
        check("ovf_pulse_end", o_ovf, 0);
        repeat (sync + 2) rd_cycle(1'b0);
        check("full_rd_count",    o_rd_count, depth);
        check("full_empty",       o_empty,    0);
        check("full_almost_empty", o_ae,      0);
    endtask

    task automatic drain_and_underflow(input int depth, input int ae, input int sync);
        for (int i = 0; i < depth; i++) begin
            rd_cycle(1'b1);
            check("drain_rdata",        o_rdata,    model.pop_front());
            check("drain_rd_count",     o_rd_count, depth - 1 - i);
            check("drain_empty",        o_empty,    i == depth - 1);
            check("drain_almost_empty", o_ae,       (depth - 1 - i) <= ae);
            check("drain_underflow",    o_unf,      0);
        end
        rd_cycle(1'b1);
        check("unf_pulse", o_unf,   1);
        check("unf_rdata", o_rdata, depth - 1);
        check("unf_empty", o_empty, 1);
        rd_cycle(1'b0);
        check("unf_pulse_end", o_unf, 0);
        repeat (sync + 2) wr_cycle(1'b0, 8'h00);
        check("drained_full",        o_full,     0);
        check("drained_wr_count",    o_wr_count, 0);
        check("drained_almost_full", o_af,       0);
    endtask

    task automatic write_visibility(input int sync);
        int n;
        n = 0;
        wr_en = 1'b1;
        wdata = 8'h5A;
        @(posedge wr_clk);
        #0.1 wr_en = 1'b0;
        while (o_empty && n < sync + 4) begin
            @(posedge rd_clk);
            #0.1;
            n++;
        end
        check("vis_latency_in_range", (n >= sync) && (n <= sync + 1) && !o_empty, 1);
        #0.9;
        check("vis_rd_count", o_rd_count, 1);
        rd_cycle(1'b1);
        check("vis_rdata", o_rdata, 8'h5A);
        check("vis_empty", o_empty, 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n_wr;
        int  n_rd;
        int  sync_d;
        logic go_w;
        logic go_r;

        sync_d = 2;
        // reset both instances
        rst = 1'b1;
        repeat (12) @(posedge wr_clk);
        #1 rst = 1'b0;
        repeat (6) rd_cycle(1'b0);
        @(posedge wr_clk);
        #1;
        sel = 1'b0;
        check_reset_values();
        sel = 1'b1;
        check_reset_values();

        // default instance, rd_clk 17 ns
        sel = 1'b0;
        fill_and_overflow(16, 14, sync_d);
        drain_and_underflow(16, 2, sync_d);
        @(posedge wr_clk);
        #1;
        write_visibility(sync_d);

        // small instance
        sel = 1'b1;
        @(posedge wr_clk);
        #1;
        fill_and_overflow(4, 3, 3);
        drain_and_underflow(4, 1, 3);
        @(posedge wr_clk);
        #1;
        write_visibility(3);

        // randomized traffic, rd_clk 7 ns, enables gated by flags
        sel = 1'b0;
        rd_half = 3.5;
        model.delete();
        repeat (4) rd_cycle(1'b0);
        @(posedge wr_clk);
        #1;
        n_wr = 0;
        n_rd = 0;
        fork
            begin
                int budget;
                budget = 0;
                while (n_wr < 1000 && budget < 20000) begin
                    go_w  = ($urandom_range(0, 1) == 1) && !o_full;
                    wr_en = go_w;
                    wdata = 8'($urandom);
                    if (go_w) begin
                        model.push_back(wdata);
                        n_wr++;
                    end
                    @(posedge wr_clk);
                    #1;
                    wr_en = 1'b0;
                    check("rand_overflow", o_ovf, 0);
                    check("rand_wr_count_pessimistic", o_wr_count >= model.size(), 1);
                    budget++;
                end
            end
            begin
                int budget;
                budget = 0;
                while (n_rd < 1000 && budget < 40000) begin
                    go_r  = ($urandom_range(0, 1) == 1) && !o_empty;
                    rd_en = go_r;
                    @(posedge rd_clk);
                    #1;
                    rd_en = 1'b0;
                    if (go_r) begin
                        if (model.size() == 0) begin
                            check("rand_model_nonempty", 0, 1);
                        end else begin
                            check("rand_rdata", o_rdata, model.pop_front());
                        end
                        n_rd++;
                    end
                    check("rand_underflow", o_unf, 0);
                    check("rand_rd_count_optimistic_bound", o_rd_count <= model.size(), 1);
                    budget++;
                end
            end
        join
        check("rand_words_written", n_wr, 1000);
        check("rand_words_read",    n_rd, 1000);

        // reset in the middle of operation with 9 entries stored
        for (int i = 0; i < 9; i++) wr_cycle(1'b1, 8'(8'h30 + i));
        repeat (4) rd_cycle(1'b0);
        @(posedge wr_clk);
        #1 rst = 1'b1;
        @(posedge wr_clk);
        #1 rst = 1'b0;
        check("midrst_full",        o_full,     0);
        check("midrst_wr_count",    o_wr_count, 0);
        check("midrst_almost_full", o_af,       0);
        check("midrst_overflow",    o_ovf,      0);
        repeat (sync_d + 1) rd_cycle(1'b0);
        check("midrst_empty",     o_empty,    1);
        check("midrst_rd_count",  o_rd_count, 0);
        check("midrst_rdata",     o_rdata,    0);
        check("midrst_underflow", o_unf,      0);
        @(posedge wr_clk);
        #1;
        repeat (sync_d + 4) wr_cycle(1'b0, 8'h00);
        check("midrst_settled_wr_count", o_wr_count, 0);
        check("midrst_settled_full",     o_full,     0);
        wr_cycle(1'b1, 8'hA5);
        repeat (sync_d + 2) rd_cycle(1'b0);
        check("post_rst_rd_count", o_rd_count, 1);
        rd_cycle(1'b1);
        check("post_rst_rdata", o_rdata, 8'hA5);
        check("post_rst_empty", o_empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
